// File: rtl/majority_voter_filt.sv
// majority_voter_filt: registered N-input majority voter with channel masking,
// a debounce filter on the voted decision and sticky per-channel dissent flags.
//
// Pipeline:
//   stage 1 : in_q/mask_q/ones/vote_q capture the current sample and its vote
//   stage 2 : out follows vote_q once it has disagreed for HOLD enabled edges;
//             each unmasked channel's in_q bit is compared with vote_q from the
//             same sample, so a channel's dissent is judged against the vote it
//             took part in.
module majority_voter_filt #(
  parameter int N_IN      = 5,
  parameter int HOLD      = 3,
  parameter int FAULT_LIM = 4,
  parameter bit TIE_VAL   = 1'b0,
  localparam int OW       = $clog2(N_IN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_IN-1:0] in,
  input  logic [N_IN-1:0] mask,
  input  logic            clear_fault,
  output logic            out,
  output logic            vote_raw,
  output logic [OW-1:0]   ones,
  output logic            valid,
  output logic [N_IN-1:0] fault
);

  // One extra bit so 2*ones never overflows when every channel votes one.
  localparam int CW = OW + 1;
  // Counter widths; a limit of 1 still needs a 1-bit register that stays 0.
  localparam int SW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int FW = (FAULT_LIM > 1) ? $clog2(FAULT_LIM) : 1;

  localparam logic [SW-1:0] STAB_LAST  = SW'(HOLD - 1);
  localparam logic [FW-1:0] FAULT_LAST = FW'(FAULT_LIM - 1);

  logic [N_IN-1:0] in_q;
  logic [N_IN-1:0] mask_q;
  logic            vote_q;
  logic [SW-1:0]   stab_cnt;
  logic [FW-1:0]   fcnt [N_IN];

  logic [OW-1:0]   ones_nxt;
  logic [OW-1:0]   act_nxt;
  logic [CW-1:0]   ones_x2;
  logic [CW-1:0]   act_w;
  logic            vote_nxt;

  // Count unmasked channels and how many of them are high.
  always_comb begin
    ones_nxt = '0;
    act_nxt  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (!mask[i]) begin
        act_nxt = act_nxt + OW'(1);
        if (in[i]) begin
          ones_nxt = ones_nxt + OW'(1);
        end
      end
    end
  end

  assign ones_x2 = {ones_nxt, 1'b0};
  assign act_w   = {1'b0, act_nxt};

  // Strict majority of active channels decides; an exact split (including no
  // active channels at all) falls back to the tie value.
  always_comb begin
    vote_nxt = TIE_VAL;
    if (ones_x2 > act_w) begin
      vote_nxt = 1'b1;
    end else if (ones_x2 < act_w) begin
      vote_nxt = 1'b0;
    end
  end

  // Stage 1: capture the sample, its popcount and the raw vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      mask_q <= '0;
      ones   <= '0;
      vote_q <= 1'b0;
      valid  <= 1'b0;
    end else if (en) begin
      in_q   <= in;
      mask_q <= mask;
      ones   <= ones_nxt;
      vote_q <= vote_nxt;
      valid  <= 1'b1;
    end
  end

  // Debounce: out only moves after vote_q has disagreed for HOLD straight edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= 1'b0;
      stab_cnt <= '0;
    end else if (en) begin
      if (vote_q == out) begin
        stab_cnt <= '0;
      end else if (stab_cnt == STAB_LAST) begin
        out      <= vote_q;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + SW'(1);
      end
    end
  end

  // Per-channel dissent streaks; clear_fault is honoured even when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        fcnt[i] <= '0;
      end
      fault <= '0;
    end else if (clear_fault) begin
      for (int i = 0; i < N_IN; i++) begin
        fcnt[i] <= '0;
      end
      fault <= '0;
    end else if (en && valid) begin
      for (int i = 0; i < N_IN; i++) begin
        if (mask_q[i]) begin
          fcnt[i] <= '0;
        end else if (in_q[i] != vote_q) begin
          // Counter parks at the last value; fault stays set until cleared.
          if (fcnt[i] == FAULT_LAST) begin
            fault[i] <= 1'b1;
          end else begin
            fcnt[i] <= fcnt[i] + FW'(1);
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  assign vote_raw = vote_q;

endmodule

// File: tb/tb_majority_voter_filt.sv
// tb_majority_voter_filt: directed scenarios plus a randomized phase. A
// behavioural model predicts the outputs after every clock edge and queues
// them; an independent monitor compares the DUT against the queue.
module tb_majority_voter_filt;

  localparam int N    = 5;
  localparam int HOLD = 3;
  localparam int LIM  = 4;
  localparam bit TIE  = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clear_fault = 1'b0;
  logic [4:0] in_v = '0;
  logic [4:0] mask_v = '0;
  logic       out;
  logic       vote_raw;
  logic [2:0] ones;
  logic       valid;
  logic [4:0] fault;

  always #5 clk = ~clk;

  majority_voter_filt #(
    .N_IN(N), .HOLD(HOLD), .FAULT_LIM(LIM), .TIE_VAL(TIE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in_v), .mask(mask_v),
    .clear_fault(clear_fault), .out(out), .vote_raw(vote_raw),
    .ones(ones), .valid(valid), .fault(fault)
  );

  typedef struct {
    bit       out;
    bit       vote;
    int       ones;
    bit       valid;
    bit [4:0] fault;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: vote from counts, debounce as a disagreement streak,
  // faults as unbounded mismatch streaks reaching the limit.
  bit       m_out, m_vote, m_valid;
  int       m_ones, m_disagree;
  bit [4:0] m_inq, m_maskq, m_fault;
  int       m_streak [5];

  function automatic void model_reset();
    m_out = 0; m_vote = 0; m_valid = 0; m_ones = 0; m_disagree = 0;
    m_inq = '0; m_maskq = '0; m_fault = '0;
    for (int i = 0; i < N; i++) m_streak[i] = 0;
  endfunction

  function automatic void model_step();
    exp_t e;
    int   act;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (en) begin
        if (m_vote != m_out) begin
          m_disagree++;
          if (m_disagree == HOLD) begin
            m_out = m_vote;
            m_disagree = 0;
          end
        end else begin
          m_disagree = 0;
        end
        if (m_valid) begin
          for (int i = 0; i < N; i++) begin
            if (m_maskq[i]) m_streak[i] = 0;
            else if (m_inq[i] != m_vote) begin
              m_streak[i]++;
              if (m_streak[i] >= LIM) m_fault[i] = 1'b1;
            end else m_streak[i] = 0;
          end
        end
      end
      if (clear_fault) begin
        m_fault = '0;
        for (int i = 0; i < N; i++) m_streak[i] = 0;
      end
      if (en) begin
        act    = $countones(~mask_v);
        m_ones = $countones(in_v & ~mask_v);
        if (2 * m_ones > act) m_vote = 1'b1;
        else if (2 * m_ones < act) m_vote = 1'b0;
        else m_vote = TIE;
        m_inq   = in_v;
        m_maskq = mask_v;
        m_valid = 1'b1;
      end
    end
    e.out = m_out; e.vote = m_vote; e.ones = m_ones;
    e.valid = m_valid; e.fault = m_fault;
    sb.push_back(e);
  endfunction

  // Monitor: compare every predicted post-edge state.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_out", int'(out), int'(e.out));
      chk("sb_vote_raw", int'(vote_raw), int'(e.vote));
      chk("sb_ones", int'(ones), e.ones);
      chk("sb_valid", int'(valid), int'(e.valid));
      chk("sb_fault", int'(fault), int'(e.fault));
    end
  end

  // One clock: drive inputs, let the model step on the edge, return at negedge+2.
  task automatic cyc(input logic [4:0] i_in, input logic [4:0] i_mask,
                     input logic i_en, input logic i_clr);
    in_v = i_in; mask_v = i_mask; en = i_en; clear_fault = i_clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #2;
  endtask

  task automatic latency_check(input string tag);
    cyc(5'b01011, 5'b00000, 1'b1, 1'b0);
    chk({tag, "_vote_e1"}, int'(vote_raw), 1);
    chk({tag, "_ones_e1"}, int'(ones), 3);
    chk({tag, "_valid_e1"}, int'(valid), 1);
    cyc(5'b01011, 5'b00000, 1'b1, 1'b0);
    cyc(5'b01011, 5'b00000, 1'b1, 1'b0);
    chk({tag, "_out_e3"}, int'(out), 0);
    cyc(5'b01011, 5'b00000, 1'b1, 1'b0);
    chk({tag, "_out_e4"}, int'(out), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] cur_in;
    logic [4:0] cur_mask;
    model_reset();
    @(negedge clk);
    #2;
    cyc(5'b11111, 5'b00000, 1'b1, 1'b0);
    cyc(5'b11111, 5'b00000, 1'b1, 1'b0);
    chk("rst_out", int'(out), 0);
    chk("rst_valid", int'(valid), 0);
    rst_n = 1'b1;

    latency_check("s1");

    // Glitch filter
    rst_n = 1'b0;
    cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
    rst_n = 1'b1;
    cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
    cyc(5'b00111, 5'b00000, 1'b1, 1'b0);
    cyc(5'b00111, 5'b00000, 1'b1, 1'b0);
    chk("glitch_vote_hi", int'(vote_raw), 1);
    for (int k = 0; k < 4; k++) begin
      cyc(5'b00001, 5'b00000, 1'b1, 1'b0);
      chk("glitch_out_low", int'(out), 0);
    end
    chk("glitch_vote_lo", int'(vote_raw), 0);

    // Masking and tie
    cyc(5'b01100, 5'b00011, 1'b1, 1'b0);
    chk("mask_ones", int'(ones), 2);
    chk("mask_vote", int'(vote_raw), 1);
    cyc(5'b00110, 5'b00001, 1'b1, 1'b0);
    chk("tie_ones", int'(ones), 2);
    chk("tie_vote", int'(vote_raw), 0);
    cyc(5'b10101, 5'b11111, 1'b1, 1'b0);
    chk("allmask_ones", int'(ones), 0);
    chk("allmask_vote", int'(vote_raw), 0);

    // Fault set, clear, re-set, mask freeze
    rst_n = 1'b0;
    cyc(5'b00111, 5'b00000, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc(5'b00111, 5'b00000, 1'b1, 1'b0);
    chk("fault_e4", int'(fault), 0);
    cyc(5'b00111, 5'b00000, 1'b1, 1'b0);
    chk("fault_e5", int'(fault), 5'b11000);
    cyc(5'b00111, 5'b00000, 1'b1, 1'b1);
    chk("fault_clr", int'(fault), 0);
    for (int k = 0; k < 3; k++) cyc(5'b00111, 5'b00000, 1'b1, 1'b0);
    chk("fault_reset_pending", int'(fault), 0);
    cyc(5'b00111, 5'b00000, 1'b1, 1'b0);
    chk("fault_reset", int'(fault), 5'b11000);
    for (int k = 0; k < 3; k++) cyc(5'b00111, 5'b10000, 1'b1, 1'b0);
    chk("fault4_frozen", int'(fault[4]), 1);
    cyc(5'b00111, 5'b10000, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) cyc(5'b00111, 5'b10000, 1'b1, 1'b0);
    chk("fault4_masked_clr", int'(fault), 5'b01000);

    // Enable stall mid-debounce
    rst_n = 1'b0;
    cyc(5'b00000, 5'b00000, 1'b1, 1'b0);
    rst_n = 1'b1;
    cyc(5'b11111, 5'b00000, 1'b1, 1'b0);
    cyc(5'b11111, 5'b00000, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cyc(5'($urandom), 5'($urandom), 1'b0, 1'b0);
    chk("stall_out", int'(out), 0);
    chk("stall_vote", int'(vote_raw), 1);
    chk("stall_ones", int'(ones), 5);
    cyc(5'b11111, 5'b00000, 1'b1, 1'b0);
    chk("stall_out_e1", int'(out), 0);
    cyc(5'b11111, 5'b00000, 1'b1, 1'b0);
    chk("stall_out_e2", int'(out), 1);

    // Async reset with out=1 and faults present
    for (int k = 0; k < 6; k++) cyc(5'b00111, 5'b00000, 1'b1, 1'b0);
    chk("pre_rst_out", int'(out), 1);
    chk("pre_rst_fault", int'(fault), 5'b11000);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_out", int'(out), 0);
    chk("arst_vote", int'(vote_raw), 0);
    chk("arst_ones", int'(ones), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_fault", int'(fault), 0);
    cyc(5'b01011, 5'b00000, 1'b1, 1'b0);
    rst_n = 1'b1;
    latency_check("recov");

    // Randomized phase
    cur_in = 5'b00000;
    cur_mask = 5'b00000;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) < 30) cur_in = 5'($urandom);
      if ($urandom_range(0, 99) < 5) cur_mask = 5'($urandom & $urandom);
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      cyc(cur_in, cur_mask, ($urandom_range(0, 99) >= 10),
          ($urandom_range(0, 39) == 0));
      rst_n = 1'b1;
    end

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
